dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with a fixed per-access stall, unaligned 32-bit access,
// out-of-range error flag and abort-on-drop request handling.
//
// Handshake: the core raises req_mem with addr/wdata/wmask/wmem and holds them while
// data_stall=1. The cycle with req_mem=1 and data_stall=0 is the completion cycle:
// rdata/data_err are valid then, and a write commits on that cycle's closing edge.
// Dropping req_mem before completion aborts the access with no side effects.
module dmem_ctrl #(
  parameter int DEPTH_BYTES = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_mem,
  input  logic        wmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        data_stall,
  output logic        data_err,
  output logic [1:0]  dbg_state
);

  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_OK  = 32'(DEPTH_BYTES - 4);
  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [DEPTH_BYTES-1:0][7:0] mem_t;

  // Storage powers up holding byte i = i[7:0]; reset never touches it.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH_BYTES; i++) begin
      m[i] = 8'(i);
    end
    return m;
  endfunction

  mem_t          mem_q = mem_init();
  state_t        state_q;
  logic [3:0]    cnt_q;

  logic          out_of_range;
  logic          complete;
  logic          wr_en;
  logic [AW-1:0] byte_idx [4];
  logic [31:0]   rd_word;

  always_comb begin
    out_of_range = addr > LAST_OK;
    complete     = req_mem && ((state_q == ST_IDLE && WAIT_CYCLES == 0) ||
                               state_q == ST_DONE);
    data_stall   = req_mem && ((state_q == ST_IDLE && WAIT_CYCLES != 0) ||
                               state_q == ST_WAIT);
    // Reset wins over a completing write on the same edge.
    wr_en        = complete && wmem && !out_of_range && !reset;
    rd_word      = '0;
    for (int k = 0; k < 4; k++) begin
      byte_idx[k]        = addr[AW-1:0] + AW'(k);
      rd_word[8*k +: 8]  = mem_q[byte_idx[k]];
    end
  end

  assign rdata     = (complete && !out_of_range) ? rd_word : 32'h0;
  assign data_err  = complete && out_of_range;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_mem && WAIT_CYCLES != 0) begin
            cnt_q   <= CNT_LOAD;
            state_q <= (WAIT_CYCLES == 1) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req_mem) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == 4'd1) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) begin
          mem_q[byte_idx[k]] <= wdata[8*k +: 8];
        end
      end
    end
  end

endmodule
